// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and the back-pressure LFSR step for the AXI4 memory target.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port with read enable.
module axi_mem_ram
#(
    parameter int DATA_W    = 512,
    parameter int ADDR_BITS = 16
)
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_W-1:0]     rdata
);
    import axi_mem_pkg::*;

    logic [DATA_W-1:0] mem [2**ADDR_BITS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Separate process with non-blocking update: a same-cycle write is not seen (read-first).
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_target_rw.sv
// AXI4 memory target with independent write (AW/W/B) and read (AR/R) FSMs over an internal RAM.
// Optional random back-pressure is compiled in with AXI_MEM_BACKPRESSURE_EN.
module axi_mem_target_rw
#(
    parameter int          DATA_W         = 512,
    parameter int          ADDR_W         = 32,
    parameter int          ID_W           = 4,
    parameter int          MEM_WORDS_LOG2 = 16,
    parameter int          READ_LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
)
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [ID_W-1:0]      s_axi_awid,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic [7:0]           s_axi_awlen,
    input  logic [1:0]           s_axi_awburst,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [DATA_W-1:0]    s_axi_wdata,
    input  logic [DATA_W/8-1:0]  s_axi_wstrb,
    input  logic                 s_axi_wlast,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [ID_W-1:0]      s_axi_bid,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ID_W-1:0]      s_axi_arid,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic [7:0]           s_axi_arlen,
    input  logic [1:0]           s_axi_arburst,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [ID_W-1:0]      s_axi_rid,
    output logic [DATA_W-1:0]    s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rlast,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready
);
    import axi_mem_pkg::*;

    localparam int         BYTE_SH  = $clog2(DATA_W/8);
    localparam int         IDX_W    = ADDR_W - BYTE_SH;
    localparam int         MW       = MEM_WORDS_LOG2;
    localparam logic [3:0] LAT_LOAD = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

    wr_state_t         wr_state_q, wr_state_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d, rd_issue_idx;
    logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              roor_q, roor_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;

    logic              rst_done_q;
    logic              wr_en, ram_re;
    logic              w_oor, w_final;
    logic              bp_w, rvalid;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_bits;

    assign unused_bits = ^{s_axi_awaddr[BYTE_SH-1:0], s_axi_araddr[BYTE_SH-1:0], LFSR_SEED};

`ifdef AXI_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        rvalid_held_q, rvalid_held_d;

    assign lfsr_d        = lfsr_next(lfsr_q);
    assign bp_w          = lfsr_q[0];
    // Withholding only applies before RVALID is first shown for a beat.
    assign rvalid        = (rd_state_q == R_DATA) && (rvalid_held_q || !lfsr_q[1]);
    assign rvalid_held_d = rvalid && !s_axi_rready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q        <= LFSR_SEED;
            rvalid_held_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            rvalid_held_q <= rvalid_held_d;
        end
    end
`else
    assign bp_w   = 1'b0;
    assign rvalid = (rd_state_q == R_DATA);
`endif

    assign w_oor   = |widx_q[IDX_W-1:MW];
    assign w_final = (wbeat_q == wlen_q);

    // Ready outputs stay low until one edge has sampled reset released.
    assign s_axi_awready = (wr_state_q == W_IDLE) && rst_done_q;
    assign s_axi_wready  = (wr_state_q == W_DATA) && !bp_w;
    assign s_axi_bvalid  = (wr_state_q == W_RESP);
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = ((wr_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_arready = (rd_state_q == R_IDLE) && rst_done_q;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = ((rd_state_q == R_DATA) && roor_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = (rd_state_q == R_DATA) && (rbeat_q == rlen_q);
    assign s_axi_rdata   = ((rd_state_q == R_DATA) && !roor_q) ? ram_rdata : '0;

    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        widx_d     = widx_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wbeat_d    = wbeat_q;
        werr_d     = werr_q;
        wr_en      = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    wid_d      = s_axi_awid;
                    widx_d     = s_axi_awaddr[ADDR_W-1:BYTE_SH];
                    wlen_d     = s_axi_awlen;
                    wburst_d   = s_axi_awburst;
                    wbeat_d    = 8'd0;
                    werr_d     = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && s_axi_wready) begin
                    wr_en  = !w_oor;
                    werr_d = werr_q | w_oor | (s_axi_wlast != w_final);
                    // The beat count, not WLAST, ends the burst.
                    if (w_final) begin
                        wr_state_d = W_RESP;
                    end else begin
                        wbeat_d = wbeat_q + 8'd1;
                        widx_d  = (wburst_q == BURST_FIXED) ? widx_q : widx_q + IDX_W'(1);
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        rid_d        = rid_q;
        ridx_d       = ridx_q;
        rlen_d       = rlen_q;
        rburst_d     = rburst_q;
        rbeat_d      = rbeat_q;
        lat_cnt_d    = lat_cnt_q;
        rd_issue_idx = ridx_q;
        ram_re       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    rid_d     = s_axi_arid;
                    ridx_d    = s_axi_araddr[ADDR_W-1:BYTE_SH];
                    rlen_d    = s_axi_arlen;
                    rburst_d  = s_axi_arburst;
                    rbeat_d   = 8'd0;
                    lat_cnt_d = LAT_LOAD;
                    if (READ_LATENCY == 0) begin
                        rd_issue_idx = s_axi_araddr[ADDR_W-1:BYTE_SH];
                        ram_re       = 1'b1;
                        rd_state_d   = R_DATA;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // RAM read is issued on the final wait cycle so data lands with RVALID.
                if (lat_cnt_q == 4'd0) begin
                    ram_re     = 1'b1;
                    rd_state_d = R_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rvalid && s_axi_rready) begin
                    if (rbeat_q == rlen_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rbeat_d      = rbeat_q + 8'd1;
                        rd_issue_idx = (rburst_q == BURST_FIXED) ? ridx_q : ridx_q + IDX_W'(1);
                        ridx_d       = rd_issue_idx;
                        ram_re       = 1'b1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        roor_d = ram_re ? (|rd_issue_idx[IDX_W-1:MW]) : roor_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rst_done_q <= 1'b0;
            wr_state_q <= W_IDLE;
            wid_q      <= '0;
            widx_q     <= '0;
            wlen_q     <= 8'd0;
            wburst_q   <= 2'b00;
            wbeat_q    <= 8'd0;
            werr_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            ridx_q     <= '0;
            rlen_q     <= 8'd0;
            rburst_q   <= 2'b00;
            rbeat_q    <= 8'd0;
            roor_q     <= 1'b0;
            lat_cnt_q  <= 4'd0;
        end else begin
            rst_done_q <= 1'b1;
            wr_state_q <= wr_state_d;
            wid_q      <= wid_d;
            widx_q     <= widx_d;
            wlen_q     <= wlen_d;
            wburst_q   <= wburst_d;
            wbeat_q    <= wbeat_d;
            werr_q     <= werr_d;
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            ridx_q     <= ridx_d;
            rlen_q     <= rlen_d;
            rburst_q   <= rburst_d;
            rbeat_q    <= rbeat_d;
            roor_q     <= roor_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    axi_mem_ram #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (MW)
    ) u_ram (
        .clk   (aclk),
        .we    (wr_en && aresetn),
        .waddr (widx_q[MW-1:0]),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .re    (ram_re),
        .raddr (rd_issue_idx[MW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_mem_target_rw.sv
// Scoreboard bench for axi_mem_target_rw: a byte-level memory model predicts B and R beats.
`timescale 1ns/1ps
module tb_axi_mem_target_rw;
    import axi_mem_pkg::*;

    localparam int DW  = 512;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int MWL = 16;
    localparam int RL  = 2;
    localparam int SW  = DW/8;
    localparam int SH  = 6;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] s_axi_awid = '0;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic [7:0]    s_axi_awlen = '0;
    logic [1:0]    s_axi_awburst = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata = '0;
    logic [SW-1:0] s_axi_wstrb = '0;
    logic          s_axi_wlast = 1'b0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [IW-1:0] s_axi_arid = '0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic [7:0]    s_axi_arlen = '0;
    logic [1:0]    s_axi_arburst = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_mem_target_rw #(
        .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .MEM_WORDS_LOG2(MWL),
        .READ_LATENCY(RL), .LFSR_SEED(16'hACE1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } rexp_t;

    typedef struct {
        logic [1:0]    resp;
        logic [IW-1:0] id;
    } bexp_t;

    rexp_t         r_q[$];
    bexp_t         b_q[$];
    logic [DW-1:0] model [longint];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic idx_oor(input longint idx);
        return (idx >> MWL) != 0;
    endfunction

    function automatic longint idx_step(input longint idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + 1;
    endfunction

    function automatic logic [DW-1:0] model_rd(input longint idx);
        if (idx_oor(idx) || !model.exists(idx)) return '0;
        return model[idx];
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_awready"}, s_axi_awready, 0);
        check({tag, "_wready"},  s_axi_wready,  0);
        check({tag, "_bvalid"},  s_axi_bvalid,  0);
        check({tag, "_bresp"},   s_axi_bresp,   0);
        check({tag, "_bid"},     s_axi_bid,     0);
        check({tag, "_arready"}, s_axi_arready, 0);
        check({tag, "_rvalid"},  s_axi_rvalid,  0);
        check({tag, "_rresp"},   s_axi_rresp,   0);
        check({tag, "_rid"},     s_axi_rid,     0);
        check({tag, "_rlast"},   s_axi_rlast,   0);
        check({tag, "_rdata"},   s_axi_rdata,   0);
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input logic [SW-1:0] strb,
                            input logic [DW-1:0] pat, input bit bad_last, input int abort_at);
        longint        idx, t;
        logic          err;
        int            cnt;
        logic [DW-1:0] beat, cur;
        bexp_t         be;
        idx = longint'(addr >> SH);
        t   = idx;
        err = bad_last;
        for (int b = 0; b <= len; b++) begin
            if (idx_oor(t)) err = 1'b1;
            t = idx_step(t, burst);
        end
        if (abort_at < 0) b_q.push_back('{err ? RESP_SLVERR : RESP_OKAY, id});

        @(negedge aclk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        cnt = 0;
        while (!s_axi_awready && cnt < 100) begin @(negedge aclk); cnt++; end
        check("aw_ready", s_axi_awready, 1);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        check("w_ready_t1", s_axi_wready, 1);

        for (int b = 0; b <= len; b++) begin
            if (b == abort_at) begin
                s_axi_wvalid = 1'b0;
                $display("WRITE addr=%h len=%0d burst=%0d id=%0d aborted at beat %0d", addr, len, burst, id, b);
                return;
            end
            beat = pat + DW'(b);
            s_axi_wdata  = beat;
            s_axi_wstrb  = strb;
            s_axi_wlast  = bad_last ? (b == 0) : (b == len);
            s_axi_wvalid = 1'b1;
            cnt = 0;
            while (!s_axi_wready && cnt < 100) begin @(negedge aclk); cnt++; end
            check("w_ready", s_axi_wready, 1);
            if (!idx_oor(idx)) begin
                cur = model_rd(idx);
                for (int k = 0; k < SW; k++) begin
                    if (strb[k]) cur[k*8 +: 8] = beat[k*8 +: 8];
                end
                model[idx] = cur;
            end
            idx = idx_step(idx, burst);
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;

        check("b_valid_t1", s_axi_bvalid, 1);
        s_axi_bready = 1'b1;
        cnt = 0;
        while (!s_axi_bvalid && cnt < 100) begin @(negedge aclk); cnt++; end
        check("b_valid", s_axi_bvalid, 1);
        if (b_q.size() > 0) begin
            be = b_q.pop_front();
            check("b_resp", s_axi_bresp, be.resp);
            check("b_id", s_axi_bid, be.id);
        end
        @(negedge aclk);
        s_axi_bready = 1'b0;
        check("aw_ready_after_b", s_axi_awready, 1);
        $display("WRITE addr=%h len=%0d burst=%0d id=%0d expected_resp=%0d", addr, len, burst, id, err ? 2 : 0);
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [IW-1:0] id, input int stall);
        longint idx;
        int     cnt, lat, beats, bubbles;
        rexp_t  e;
        idx = longint'(addr >> SH);
        for (int b = 0; b <= len; b++) begin
            r_q.push_back('{model_rd(idx), idx_oor(idx) ? RESP_SLVERR : RESP_OKAY, (b == len), id});
            idx = idx_step(idx, burst);
        end

        @(negedge aclk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        cnt = 0;
        while (!s_axi_arready && cnt < 100) begin @(negedge aclk); cnt++; end
        check("ar_ready", s_axi_arready, 1);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = (stall == 0);
        lat = 1;
        while (!s_axi_rvalid && lat < 64) begin @(negedge aclk); lat++; end
        check("r_latency", lat, RL + 1);

        for (int s = 0; s < stall; s++) begin
            check("r_stall_valid", s_axi_rvalid, 1);
            check("r_stall_data", s_axi_rdata, r_q[0].data);
            check("r_stall_last", s_axi_rlast, r_q[0].last);
            @(negedge aclk);
        end
        s_axi_rready = 1'b1;

        beats = 0; bubbles = 0; cnt = 0;
        while (beats <= len && cnt < 2000) begin
            if (s_axi_rvalid) begin
                e = r_q.pop_front();
                check("r_data", s_axi_rdata, e.data);
                check("r_resp", s_axi_rresp, e.resp);
                check("r_last", s_axi_rlast, e.last);
                check("r_id", s_axi_rid, e.id);
                beats++;
            end else begin
                bubbles++;
            end
            @(negedge aclk);
            cnt++;
        end
        s_axi_rready = 1'b0;
        check("r_beats", beats, len + 1);
        check("r_bubbles", bubbles, 0);
        check("r_done", s_axi_rvalid, 0);
        r_q.delete();
        $display("READ  addr=%h len=%0d burst=%0d id=%0d beats=%0d stall=%0d", addr, len, burst, id, beats, stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_outs("rst_init");
        aresetn = 1'b1;
        @(negedge aclk);
        check("awready_release", s_axi_awready, 1);
        check("arready_release", s_axi_arready, 1);

        // Basic INCR write and readback.
        wr_burst(32'h0000_0100, 3, BURST_INCR, 4'h3, '1, 512'd1, 1'b0, -1);
        rd_burst(32'h0000_0100, 3, BURST_INCR, 4'h5, 0);

        // Partial strobe over a filled word.
        wr_burst(32'h0000_0200, 0, BURST_INCR, 4'h1, '1, {64{8'hAA}}, 1'b0, -1);
        wr_burst(32'h0000_0200, 0, BURST_INCR, 4'h2, 64'h0000_0000_0000_00FF, {64{8'h55}}, 1'b0, -1);
        rd_burst(32'h0000_0200, 0, BURST_INCR, 4'h6, 0);

        // Out-of-range write must not alias onto word 0.
        wr_burst(32'h0000_0000, 0, BURST_INCR, 4'h4, '1, {16{32'hDEAD_BEEF}}, 1'b0, -1);
        wr_burst(32'h0100_0000, 1, BURST_INCR, 4'h7, '1, {16{32'h1234_5678}}, 1'b0, -1);
        rd_burst(32'h0100_0000, 1, BURST_INCR, 4'h8, 0);
        rd_burst(32'h0000_0000, 0, BURST_INCR, 4'h9, 0);

        // WLAST on the wrong beat.
        wr_burst(32'h0000_0300, 1, BURST_INCR, 4'hB, '1, {8{64'hCAFE_0000_0000_0000}}, 1'b1, -1);
        rd_burst(32'h0000_0300, 1, BURST_INCR, 4'hC, 0);

        // RREADY held low for 5 cycles.
        rd_burst(32'h0000_0100, 3, BURST_INCR, 4'hD, 5);

        // Reset in the middle of a 16-beat write.
        wr_burst(32'h0000_1000, 15, BURST_INCR, 4'hA, '1, {16{32'h0BAD_F00D}}, 1'b0, 8);
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_outs("rst_mid");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("awready_rst_mid", s_axi_awready, 1);
        check("arready_rst_mid", s_axi_arready, 1);
        rd_burst(32'h0000_1000, 7, BURST_INCR, 4'hE, 0);

        // 256-beat bursts: INCR fill, FIXED overwrite of the first word, INCR read.
        wr_burst(32'h0001_0000, 255, BURST_INCR,  4'h1, '1, {16{32'h5000_0000}}, 1'b0, -1);
        wr_burst(32'h0001_0000, 255, BURST_FIXED, 4'h2, '1, {16{32'h6000_0000}}, 1'b0, -1);
        rd_burst(32'h0001_0000, 255, BURST_INCR,  4'hF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
